multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multicycle RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback states and drives the datapath enables and muxes. It publishes the packed `ALU_CONTROL` word {opcode, state} that the ALU-control decoder consumes. It also counts retired instructions and raises `HALT` on ECALL.

## Interface
Parameters:
- `NUM_INST_W`, 32, width of retired-instruction counter

Ports:
- `CLK`  in  1  clock; all state changes on rising edge
- `RSTn`  in  1  reset, synchronous, active-low
- `INSTR`  in  32  instruction word from I-mem, valid when `I_MEM_READY`=1
- `I_MEM_READY`  in  1  fetch data valid this cycle
- `D_MEM_READY`  in  1  data access complete this cycle
- `BR_TAKEN`  in  1  ALU compare result, valid in BR_EX
- `ALU_CONTROL`  out  11  {OP[6:0], STATE[3:0]}
- `I_MEM_CSN`  out  1  active-low fetch request
- `D_MEM_CSN`  out  1  active-low data request
- `D_MEM_WEN`  out  1  active-low data write (SW only)
- `IR_WE`, `PC_WE`, `RF_WE`  out  1 each  register write enables
- `ALU_SRC_A`  out  2  0=PC, 1=rs1, 2=OLD_PC, 3=zero
- `ALU_SRC_B`  out  2  0=rs2, 1=imm, 2=const 4
- `PC_SEL`  out  2  0=ALU result, 1=ALUOut reg, 2=ALU result & ~1
- `WB_SEL`  out  2  0=ALUOut, 1=mem data, 2=PC (already PC+4)
- `NUM_INST`  out  `NUM_INST_W`  retired-instruction count
- `HALT`  out  1  sticky halt flag

## Operation
- State encoding:
  - IF=0001, ID=0010, JAL=0011, EX_I=0101, MEM=0110, EX_R=0111, JALR=1000, BR_EX=1001, WB=1010, UPPER=1011, HALT_ST=1111.
- OP register captures `INSTR[6:0]` in IF when `I_MEM_READY`=1.
- `ALU_CONTROL`={OP,STATE} is driven directly from registers, with no combinational path from inputs.
- IF:
  - `I_MEM_CSN`=0, `ALU_SRC_A`=0, `ALU_SRC_B`=2, `PC_SEL`=0.
  - `IR_WE`=`PC_WE`=`I_MEM_READY`.
  - Stay in IF while not ready; go to ID when ready.
- ID:
  - `ALU_SRC_A`=2, `ALU_SRC_B`=1 (branch target into ALUOut).
  - Next state by OP:
    - 0000011 or 0100011 or 0010011 → EX_I
    - 0110011 → EX_R
    - 1100011 → BR_EX
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 or 0010111 → UPPER
    - 1110011 → HALT_ST
    - any other OP → IF, counted as retired (NOP).
- EX_I: A=1, B=1. Loads/stores → MEM; I-type → WB.
- MEM:
  - `D_MEM_CSN`=0; `D_MEM_WEN`=0 only for OP 0100011.
  - Hold until `D_MEM_READY`.
  - When ready: load → WB with `WB_SEL`=1 latched; store → IF, retire.
- EX_R: A=1, B=0 → WB.
- WB: `RF_WE`=1 for exactly one cycle; `WB_SEL`=1 if OP=load, else 0 → IF, retire.
- BR_EX: A=1, B=0; `PC_WE`=`BR_TAKEN`, `PC_SEL`=1 → IF, retire.
- JAL: A=2, B=1; `PC_WE`=1, `PC_SEL`=0; `RF_WE`=1, `WB_SEL`=2 → IF, retire.
- JALR: A=1, B=1; `PC_WE`=1, `PC_SEL`=2; `RF_WE`=1, `WB_SEL`=2 → IF, retire.
- UPPER: A=3 for LUI, A=2 for AUIPC; B=1 → WB.
- HALT_ST:
  - `HALT`=1; absorbing until reset.
  - All enables 0, CSNs 1.
- Retire: `NUM_INST` increments by 1 on the edge leaving the final state. It wraps modulo 2^`NUM_INST_W`.
- Default output in every state unless listed:
  - enables 0, CSNs/WEN 1, mux selects 0.

## Timing
- Reset (`RSTn`=0 at a rising edge), effective next edge, overriding any state including HALT_ST or a pending MEM wait:
  - STATE=IF, OP=0, `NUM_INST`=0, `HALT`=0.
  - Outputs in reset cycle: `IR_WE`=`PC_WE`=`RF_WE`=0, `I_MEM_CSN`=`D_MEM_CSN`=`D_MEM_WEN`=1, all selects 0.
- Data-access handshake:
  - Request held asserted every cycle until ready is sampled high.
  - Request drops the cycle after ready.
  - Ready while not requesting is ignored.
- Fetch handshake:
  - `I_MEM_CSN`=0 in every IF cycle and only in IF.
  - `IR_WE`/`PC_WE` assert only in the IF cycle where `I_MEM_READY`=1; the FSM leaves IF on the next edge.
- Minimum latency with zero-wait memory, in cycles:
  - branch 3
  - R/I-type 4
  - JAL/JALR 3
  - LUI/AUIPC 4
  - SW 4
  - LW 5
- Each wait cycle adds exactly one cycle.
- `PC_WE`, `IR_WE` and `D_MEM_WEN` are Mealy outputs gated by ready/`BR_TAKEN`; everything else is Moore.

## Test plan
- Reset held mid-MEM wait with `D_MEM_CSN`=0 → next cycle STATE=0001, `D_MEM_CSN`=1, `NUM_INST`=0, `ALU_CONTROL`=11'h001.
- ADD (0x002081B3), zero-wait:
  - States IF→ID→EX_R→WB, with `ALU_CONTROL`=11'h337 in EX_R.
  - `RF_WE` high 1 cycle; `NUM_INST` 0→1 after 4 cycles.
- LW with `D_MEM_READY` low 3 cycles → MEM held 4 cycles, WB `WB_SEL`=1, total 8 cycles, `D_MEM_WEN`=1 throughout.
- SW (OP 0100011) zero-wait → `D_MEM_WEN`=0 exactly one cycle in MEM, no `RF_WE`, return to IF after 4 cycles.
- BEQ with `BR_TAKEN`=1 then `BR_TAKEN`=0:
  - `ALU_CONTROL`=11'h639 in BR_EX.
  - `PC_WE`=1, `PC_SEL`=1 only in the taken case.
- ECALL (0x00000073) → HALT_ST reached after ID, `HALT`=1 stays high for 100 cycles, `I_MEM_CSN`=1, `NUM_INST` frozen until `RSTn`=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core (IF/ID/EX/MEM/WB sequencing).
// Latency: 3 cycles (branch, JAL, JALR), 4 cycles (R/I-type, LUI/AUIPC, SW), 5 cycles (LW) with zero-wait memory.
// Backpressure: IF holds until I_MEM_READY and MEM holds until D_MEM_READY; each wait cycle adds one cycle.
//
// Ports:
//   CLK, RSTn        clock and synchronous active-low reset
//   INSTR            fetched instruction word; only the opcode field is consumed
//   I_MEM_READY      fetch data valid; D_MEM_READY data access complete
//   BR_TAKEN         branch compare result, used in BR_EX only
//   ALU_CONTROL      {opcode register, state register}, purely registered
//   I_MEM_CSN, D_MEM_CSN, D_MEM_WEN   active-low memory requests / write strobe
//   IR_WE, PC_WE, RF_WE               register write enables
//   ALU_SRC_A/B, PC_SEL, WB_SEL       datapath mux selects
//   NUM_INST         retired-instruction counter (wraps)
//   HALT             sticky halt flag, set by ECALL, cleared only by reset
module multicycle_ctrl #(
  parameter int NUM_INST_W = 32
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic [31:0]           INSTR,
  input  logic                  I_MEM_READY,
  input  logic                  D_MEM_READY,
  input  logic                  BR_TAKEN,
  output logic [10:0]           ALU_CONTROL,
  output logic                  I_MEM_CSN,
  output logic                  D_MEM_CSN,
  output logic                  D_MEM_WEN,
  output logic                  IR_WE,
  output logic                  PC_WE,
  output logic                  RF_WE,
  output logic [1:0]            ALU_SRC_A,
  output logic [1:0]            ALU_SRC_B,
  output logic [1:0]            PC_SEL,
  output logic [1:0]            WB_SEL,
  output logic [NUM_INST_W-1:0] NUM_INST,
  output logic                  HALT
);

  // State encoding is visible to the ALU-control decoder through ALU_CONTROL.
  typedef enum logic [3:0] {
    S_IF    = 4'b0001,
    S_ID    = 4'b0010,
    S_JAL   = 4'b0011,
    S_EX_I  = 4'b0101,
    S_MEM   = 4'b0110,
    S_EX_R  = 4'b0111,
    S_JALR  = 4'b1000,
    S_BR_EX = 4'b1001,
    S_WB    = 4'b1010,
    S_UPPER = 4'b1011,
    S_HALT  = 4'b1111
  } state_e;

  // RV32I major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // ALU operand A selects
  localparam logic [1:0] A_PC     = 2'd0;
  localparam logic [1:0] A_RS1    = 2'd1;
  localparam logic [1:0] A_OLD_PC = 2'd2;
  localparam logic [1:0] A_ZERO   = 2'd3;
  // ALU operand B selects
  localparam logic [1:0] B_RS2    = 2'd0;
  localparam logic [1:0] B_IMM    = 2'd1;
  localparam logic [1:0] B_FOUR   = 2'd2;
  // PC source selects
  localparam logic [1:0] PC_ALU     = 2'd0;
  localparam logic [1:0] PC_ALU_OUT = 2'd1;
  localparam logic [1:0] PC_ALU_LSB = 2'd2;
  // Writeback selects
  localparam logic [1:0] WB_ALU_OUT = 2'd0;
  localparam logic [1:0] WB_MEM     = 2'd1;
  localparam logic [1:0] WB_PC      = 2'd2;

  state_e                  state_q, state_d;
  logic [6:0]              op_q, op_d;
  logic [NUM_INST_W-1:0]   num_inst_q, num_inst_d;
  logic                    halt_q, halt_d;
  logic                    retire;

  logic is_load;
  logic is_store;

  // Only the opcode field drives control; the rest of the word feeds the datapath.
  logic unused_instr_hi;
  assign unused_instr_hi = ^INSTR[31:7];

  assign is_load  = (op_q == OP_LOAD);
  assign is_store = (op_q == OP_STORE);

  assign ALU_CONTROL = {op_q, state_q};
  assign NUM_INST    = num_inst_q;
  assign HALT        = halt_q;

  // ---------------------------------------------------------------------------
  // State, opcode, counter and halt registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= S_IF;
      op_q       <= '0;
      num_inst_q <= '0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      num_inst_q <= num_inst_d;
      halt_q     <= halt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic; 'retire' marks the last cycle of every instruction
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    halt_d  = halt_q;
    retire  = 1'b0;

    case (state_q)
      S_IF: begin
        if (I_MEM_READY) begin
          op_d    = INSTR[6:0];
          state_d = S_ID;
        end
      end

      S_ID: begin
        case (op_q)
          OP_LOAD, OP_STORE, OP_IMM: state_d = S_EX_I;
          OP_REG:                    state_d = S_EX_R;
          OP_BRANCH:                 state_d = S_BR_EX;
          OP_JAL:                    state_d = S_JAL;
          OP_JALR:                   state_d = S_JALR;
          OP_LUI, OP_AUIPC:          state_d = S_UPPER;
          OP_SYSTEM: begin
            state_d = S_HALT;
            halt_d  = 1'b1;
          end
          default: begin
            // Unknown opcodes execute as a NOP and still count as retired.
            state_d = S_IF;
            retire  = 1'b1;
          end
        endcase
      end

      S_EX_I: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        if (D_MEM_READY) begin
          if (is_store) begin
            state_d = S_IF;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_EX_R, S_UPPER: begin
        state_d = S_WB;
      end

      S_WB, S_BR_EX, S_JAL, S_JALR: begin
        state_d = S_IF;
        retire  = 1'b1;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IF;
      end
    endcase

    num_inst_d = retire ? num_inst_q + NUM_INST_W'(1) : num_inst_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath controls. Everything is decoded from state_q/op_q except the
  // write strobes, which are qualified by the ready/compare inputs. During
  // the reset cycle all controls sit at their idle values.
  // ---------------------------------------------------------------------------
  always_comb begin
    IR_WE     = 1'b0;
    PC_WE     = 1'b0;
    RF_WE     = 1'b0;
    I_MEM_CSN = 1'b1;
    D_MEM_CSN = 1'b1;
    D_MEM_WEN = 1'b1;
    ALU_SRC_A = A_PC;
    ALU_SRC_B = B_RS2;
    PC_SEL    = PC_ALU;
    WB_SEL    = WB_ALU_OUT;

    if (RSTn) begin
      case (state_q)
        S_IF: begin
          // PC + 4 computed in the ALU and written alongside the IR.
          I_MEM_CSN = 1'b0;
          ALU_SRC_A = A_PC;
          ALU_SRC_B = B_FOUR;
          PC_SEL    = PC_ALU;
          IR_WE     = I_MEM_READY;
          PC_WE     = I_MEM_READY;
        end

        S_ID: begin
          // Speculative branch target (old PC + imm) lands in ALUOut.
          ALU_SRC_A = A_OLD_PC;
          ALU_SRC_B = B_IMM;
        end

        S_EX_I: begin
          ALU_SRC_A = A_RS1;
          ALU_SRC_B = B_IMM;
        end

        S_MEM: begin
          D_MEM_CSN = 1'b0;
          D_MEM_WEN = ~(is_store && D_MEM_READY);
        end

        S_EX_R: begin
          ALU_SRC_A = A_RS1;
          ALU_SRC_B = B_RS2;
        end

        S_WB: begin
          RF_WE  = 1'b1;
          WB_SEL = is_load ? WB_MEM : WB_ALU_OUT;
        end

        S_BR_EX: begin
          // Compare rs1/rs2; the target was already computed during ID.
          ALU_SRC_A = A_RS1;
          ALU_SRC_B = B_RS2;
          PC_SEL    = PC_ALU_OUT;
          PC_WE     = BR_TAKEN;
        end

        S_JAL: begin
          // PC register already holds PC+4, so it is the link value.
          ALU_SRC_A = A_OLD_PC;
          ALU_SRC_B = B_IMM;
          PC_WE     = 1'b1;
          PC_SEL    = PC_ALU;
          RF_WE     = 1'b1;
          WB_SEL    = WB_PC;
        end

        S_JALR: begin
          ALU_SRC_A = A_RS1;
          ALU_SRC_B = B_IMM;
          PC_WE     = 1'b1;
          PC_SEL    = PC_ALU_LSB;
          RF_WE     = 1'b1;
          WB_SEL    = WB_PC;
        end

        S_UPPER: begin
          ALU_SRC_A = (op_q == OP_LUI) ? A_ZERO : A_OLD_PC;
          ALU_SRC_B = B_IMM;
        end

        default: begin
          // S_HALT and any unreachable code: idle controls.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-cycle check of multicycle_ctrl against an instruction-level plan model.
// Latency: the model expands each instruction into its expected cycle sequence, including wait cycles.
// Backpressure: I_MEM_READY/D_MEM_READY wait counts are directed or randomized per instruction.
module tb_multicycle_ctrl;

  localparam int W = 4;   // narrow counter so wrap-around is reached quickly

  localparam logic [3:0] ST_IF   = 4'h1;
  localparam logic [3:0] ST_ID   = 4'h2;
  localparam logic [3:0] ST_JAL  = 4'h3;
  localparam logic [3:0] ST_EX_I = 4'h5;
  localparam logic [3:0] ST_MEM  = 4'h6;
  localparam logic [3:0] ST_EX_R = 4'h7;
  localparam logic [3:0] ST_JALR = 4'h8;
  localparam logic [3:0] ST_BR   = 4'h9;
  localparam logic [3:0] ST_WB   = 4'hA;
  localparam logic [3:0] ST_UP   = 4'hB;
  localparam logic [3:0] ST_HALT = 4'hF;

  // {IR_WE,PC_WE,RF_WE,I_MEM_CSN,D_MEM_CSN,D_MEM_WEN,A,B,PC_SEL,WB_SEL}
  localparam logic [13:0] IDLE = {3'b000, 3'b111, 8'h00};

  logic            CLK = 1'b0;
  logic            RSTn;
  logic [31:0]     INSTR;
  logic            I_MEM_READY, D_MEM_READY, BR_TAKEN;
  logic [10:0]     ALU_CONTROL;
  logic            I_MEM_CSN, D_MEM_CSN, D_MEM_WEN, IR_WE, PC_WE, RF_WE;
  logic [1:0]      ALU_SRC_A, ALU_SRC_B, PC_SEL, WB_SEL;
  logic [W-1:0]    NUM_INST;
  logic            HALT;
  logic [13:0]     ctrl_obs;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        imr, dmr, brt;
    logic [6:0]  op;
    logic [3:0]  st;
    logic [13:0] ctrl;
    logic        chk_wen;
    logic        halt;
  } cyc_t;

  cyc_t         plan[$];
  logic [6:0]   cur_op;
  logic [W-1:0] exp_cnt;
  logic [31:0]  instr_word;
  string        label;

  multicycle_ctrl #(.NUM_INST_W(W)) dut (
    .CLK(CLK), .RSTn(RSTn), .INSTR(INSTR), .I_MEM_READY(I_MEM_READY),
    .D_MEM_READY(D_MEM_READY), .BR_TAKEN(BR_TAKEN), .ALU_CONTROL(ALU_CONTROL),
    .I_MEM_CSN(I_MEM_CSN), .D_MEM_CSN(D_MEM_CSN), .D_MEM_WEN(D_MEM_WEN),
    .IR_WE(IR_WE), .PC_WE(PC_WE), .RF_WE(RF_WE), .ALU_SRC_A(ALU_SRC_A),
    .ALU_SRC_B(ALU_SRC_B), .PC_SEL(PC_SEL), .WB_SEL(WB_SEL),
    .NUM_INST(NUM_INST), .HALT(HALT)
  );

  assign ctrl_obs = {IR_WE, PC_WE, RF_WE, I_MEM_CSN, D_MEM_CSN, D_MEM_WEN,
                     ALU_SRC_A, ALU_SRC_B, PC_SEL, WB_SEL};

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] ctl(input int ir, input int pc, input int rf,
                                      input int icsn, input int dcsn, input int dwen,
                                      input int a, input int b, input int ps, input int ws);
    return {ir[0], pc[0], rf[0], icsn[0], dcsn[0], dwen[0], a[1:0], b[1:0], ps[1:0], ws[1:0]};
  endfunction

  // Append one expected cycle; negative input values mean "drive randomly".
  task automatic add(input logic [3:0] st, input logic [13:0] c,
                     input int imr, input int dmr, input int brt, input int cw);
    cyc_t e;
    e.imr     = (imr < 0) ? 1'($urandom) : imr[0];
    e.dmr     = (dmr < 0) ? 1'($urandom) : dmr[0];
    e.brt     = (brt < 0) ? 1'($urandom) : brt[0];
    e.op      = cur_op;
    e.st      = st;
    e.ctrl    = c;
    e.chk_wen = cw[0];
    e.halt    = (st == ST_HALT);
    plan.push_back(e);
  endtask

  // Expand one instruction into its expected cycle-by-cycle behaviour.
  task automatic build(input logic [31:0] word, input int iw, input int dw, input logic br,
                       input int nhalt, output logic retires);
    logic [6:0] op;
    op = word[6:0];
    instr_word = word;
    plan.delete();
    for (int k = 0; k < iw; k++) add(ST_IF, ctl(0,0,0,0,1,1,0,2,0,0), 0, -1, -1, 1);
    add(ST_IF, ctl(1,1,0,0,1,1,0,2,0,0), 1, -1, -1, 1);
    cur_op = op;
    add(ST_ID, ctl(0,0,0,1,1,1,2,1,0,0), -1, -1, -1, 1);
    retires = 1'b1;
    case (op)
      7'h03: begin
        add(ST_EX_I, ctl(0,0,0,1,1,1,1,1,0,0), -1, -1, -1, 1);
        for (int k = 0; k < dw; k++) add(ST_MEM, ctl(0,0,0,1,0,1,0,0,0,0), -1, 0, -1, 1);
        add(ST_MEM, ctl(0,0,0,1,0,1,0,0,0,0), -1, 1, -1, 1);
        add(ST_WB, ctl(0,0,1,1,1,1,0,0,0,1), -1, -1, -1, 1);
      end
      7'h23: begin
        add(ST_EX_I, ctl(0,0,0,1,1,1,1,1,0,0), -1, -1, -1, 1);
        for (int k = 0; k < dw; k++) add(ST_MEM, ctl(0,0,0,1,0,1,0,0,0,0), -1, 0, -1, 0);
        add(ST_MEM, ctl(0,0,0,1,0,0,0,0,0,0), -1, 1, -1, 1);
      end
      7'h13: begin
        add(ST_EX_I, ctl(0,0,0,1,1,1,1,1,0,0), -1, -1, -1, 1);
        add(ST_WB, ctl(0,0,1,1,1,1,0,0,0,0), -1, -1, -1, 1);
      end
      7'h33: begin
        add(ST_EX_R, ctl(0,0,0,1,1,1,1,0,0,0), -1, -1, -1, 1);
        add(ST_WB, ctl(0,0,1,1,1,1,0,0,0,0), -1, -1, -1, 1);
      end
      7'h63: add(ST_BR, ctl(0,int'(br),0,1,1,1,1,0,1,0), -1, -1, int'(br), 1);
      7'h6F: add(ST_JAL, ctl(0,1,1,1,1,1,2,1,0,2), -1, -1, -1, 1);
      7'h67: add(ST_JALR, ctl(0,1,1,1,1,1,1,1,2,2), -1, -1, -1, 1);
      7'h37, 7'h17: begin
        add(ST_UP, ctl(0,0,0,1,1,1,(op == 7'h37) ? 3 : 2,1,0,0), -1, -1, -1, 1);
        add(ST_WB, ctl(0,0,1,1,1,1,0,0,0,0), -1, -1, -1, 1);
      end
      7'h73: begin
        retires = 1'b0;
        for (int k = 0; k < nhalt; k++) add(ST_HALT, IDLE, -1, -1, -1, 1);
      end
      default: ;  // NOP: straight back to fetch
    endcase
  endtask

  task automatic run_plan(input int ncyc);
    cyc_t e;
    logic [13:0] o;
    for (int i = 0; i < plan.size() && i < ncyc; i++) begin
      e = plan[i];
      I_MEM_READY = e.imr;
      D_MEM_READY = e.dmr;
      BR_TAKEN    = e.brt;
      INSTR       = (e.st == ST_IF && e.imr) ? instr_word : $urandom;
      @(negedge CLK);
      o = ctrl_obs;
      if (!e.chk_wen) o[8] = e.ctrl[8];
      check($sformatf("%s c%0d alu_control", label, i), 32'(ALU_CONTROL), 32'({e.op, e.st}));
      check($sformatf("%s c%0d ctrl", label, i), 32'(o), 32'(e.ctrl));
      check($sformatf("%s c%0d num_inst", label, i), 32'(NUM_INST), 32'(exp_cnt));
      check($sformatf("%s c%0d halt", label, i), 32'(HALT), 32'(e.halt));
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_instr(input string lbl, input logic [31:0] word, input int iw, input int dw,
                          input logic br, input int nhalt);
    logic r;
    label = lbl;
    build(word, iw, dw, br, nhalt, r);
    run_plan(plan.size());
    if (r) exp_cnt += 1;
  endtask

  // Assert reset for one edge (outputs idle), then check the post-reset IF cycle.
  task automatic do_reset(input string tag, input logic [10:0] alu_pre, input logic halt_pre);
    RSTn        = 1'b0;
    I_MEM_READY = 1'($urandom);
    D_MEM_READY = 1'($urandom);
    BR_TAKEN    = 1'($urandom);
    INSTR       = $urandom;
    @(negedge CLK);
    check({tag, " rst alu_control"}, 32'(ALU_CONTROL), 32'(alu_pre));
    check({tag, " rst ctrl"}, 32'(ctrl_obs), 32'(IDLE));
    check({tag, " rst halt"}, 32'(HALT), 32'(halt_pre));
    @(posedge CLK);
    #1;
    RSTn        = 1'b1;
    I_MEM_READY = 1'b0;
    D_MEM_READY = 1'($urandom);
    INSTR       = $urandom;
    @(negedge CLK);
    check({tag, " post alu_control"}, 32'(ALU_CONTROL), 32'(11'h001));
    check({tag, " post ctrl"}, 32'(ctrl_obs), 32'(ctl(0,0,0,0,1,1,0,2,0,0)));
    check({tag, " post num_inst"}, 32'(NUM_INST), 32'(0));
    check({tag, " post halt"}, 32'(HALT), 32'(0));
    cur_op  = 7'h00;
    exp_cnt = '0;
    @(posedge CLK);
    #1;
  endtask

  logic [6:0] ops [13] = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h63, 7'h6F, 7'h67,
                           7'h37, 7'h17, 7'h0F, 7'h00, 7'h7F, 7'h0B};

  initial begin
    logic [6:0] rop;
    logic       r;
    RSTn = 1'b0; I_MEM_READY = 1'b0; D_MEM_READY = 1'b0; BR_TAKEN = 1'b0; INSTR = '0;
    cur_op = 7'h00; exp_cnt = '0; instr_word = '0; label = "init";
    @(posedge CLK);
    #1;
    do_reset("por", 11'h001, 1'b0);

    // Directed instruction classes, zero-wait unless noted
    do_instr("add",     32'h002081B3, 0, 0, 1'b0, 0);
    do_instr("lw_w3",   32'h0000A183, 0, 3, 1'b0, 0);
    do_instr("sw",      32'h0030A023, 0, 0, 1'b0, 0);
    do_instr("beq_t",   32'h00208463, 0, 0, 1'b1, 0);
    do_instr("beq_nt",  32'h00208463, 0, 0, 1'b0, 0);
    do_instr("jal",     32'h008000EF, 0, 0, 1'b0, 0);
    do_instr("jalr",    32'h000080E7, 0, 0, 1'b0, 0);
    do_instr("lui",     32'h123450B7, 0, 0, 1'b0, 0);
    do_instr("auipc",   32'h00001097, 0, 0, 1'b0, 0);
    do_instr("addi_iw", 32'h00108093, 2, 0, 1'b0, 0);
    do_instr("fence",   32'h0000000F, 0, 0, 1'b0, 0);
    do_instr("sw_w2",   32'h0030A023, 1, 2, 1'b0, 0);

    // Reset while a load is waiting in MEM with D_MEM_CSN asserted
    label = "lw_rst";
    build(32'h0000A183, 0, 5, 1'b0, 0, r);
    run_plan(4);
    do_reset("mid_mem", {7'h03, 4'h6}, 1'b0);

    // Randomized instruction mix; more than 2^W retirements exercises wrap
    for (int n = 0; n < 50; n++) begin
      rop = ops[$urandom_range(0, 12)];
      do_instr($sformatf("rand%0d", n), {25'($urandom), rop},
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 0);
    end

    // ECALL: absorbing halt for 100 cycles, then reset recovers
    do_instr("ecall", 32'h00000073, 1, 0, 1'b0, 100);
    do_reset("halt", {7'h73, 4'hF}, 1'b1);
    do_instr("add_after", 32'h002081B3, 0, 0, 1'b0, 0);
    do_instr("lw_after",  32'h0000A183, 1, 1, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
